fir_frame_sequencer: RTL and testbench

//  Sequences the 32-tap parallel FIR_Filter datapath for the EEG chain.

---
 rtl/fir_frame_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fir_frame_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_frame_sequencer
// Description : Frames serial EEG samples for a 32-tap parallel FIR, pulses
//               the load strobe, waits out the filter latency, captures the
//               parallel results into an output buffer and streams them out
//               one word per beat. The next frame fills while the previous
//               one drains.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_frame_sequencer #(
  parameter int FRAME_LEN = 32,
  parameter int DIN_W     = 12,
  parameter int DOUT_W    = 29,
  parameter int FIR_LAT   = 2,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DIN_W-1:0]              s_data,
  output logic                          fir_load,
  output logic [FRAME_LEN*DIN_W-1:0]    fir_din,
  input  logic [FRAME_LEN*DOUT_W-1:0]   fir_dout,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DOUT_W-1:0]             m_data,
  output logic                          m_last,
  output logic                          busy,
  output logic [CNT_W-1:0]              frame_cnt
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int WC_W  = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [WC_W-1:0]  WC_INIT  = WC_W'(FIR_LAT - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } in_state_t;

  in_state_t                   in_st, in_st_nxt;
  logic [WC_W-1:0]             wcnt, wcnt_nxt;
  logic [IDX_W-1:0]            wr_idx, rd_idx;
  logic [FRAME_LEN*DOUT_W-1:0] obuf;
  logic                        occ;
  logic                        s_hs, m_hs, out_last_hs, out_free, capture;
  logic [DOUT_W-1:0]           words [FRAME_LEN];

  // Output side is "free" when empty or when its final word leaves this cycle,
  // which lets a waiting frame slide in with no gap in m_valid.
  assign s_hs        = s_valid & s_ready;
  assign m_hs        = occ & m_ready;
  assign out_last_hs = m_hs & (rd_idx == LAST_IDX);
  assign out_free    = ~occ | out_last_hs;

  // Input state register and latency down-counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_st <= FILL;
      wcnt  <= '0;
    end else begin
      in_st <= in_st_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Input FSM next-state, handshake and strobe decode
  always_comb begin
    in_st_nxt = in_st;
    wcnt_nxt  = wcnt;
    s_ready   = 1'b0;
    fir_load  = 1'b0;
    capture   = 1'b0;
    case (in_st)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid && (wr_idx == LAST_IDX)) in_st_nxt = LOAD;
      end
      LOAD: begin
        fir_load  = 1'b1;
        wcnt_nxt  = WC_INIT;
        in_st_nxt = WAIT;
      end
      WAIT: begin
        if (wcnt == '0) begin
          if (out_free) begin
            capture   = 1'b1;
            in_st_nxt = FILL;
          end else begin
            in_st_nxt = HOLD;
          end
        end else begin
          wcnt_nxt = wcnt - WC_W'(1);
        end
      end
      HOLD: begin
        if (out_free) begin
          capture   = 1'b1;
          in_st_nxt = FILL;
        end
      end
      default: in_st_nxt = FILL;
    endcase
  end

  // Write pointer into the input frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx <= '0;
    end else if (s_hs) begin
      wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + IDX_W'(1);
    end
  end

  // Frame slots; only written on accepted samples, so stable from LOAD to capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fir_din <= '0;
    end else if (s_hs) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        if (wr_idx == IDX_W'(k)) fir_din[k*DIN_W +: DIN_W] <= s_data;
      end
    end
  end

  // Output buffer, occupancy, read pointer and frame counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      obuf      <= '0;
      occ       <= 1'b0;
      rd_idx    <= '0;
      frame_cnt <= '0;
    end else begin
      if (capture) begin
        obuf      <= fir_dout;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (m_hs) begin
        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IDX_W'(1);
      end
      if (capture) begin
        occ <= 1'b1;
      end else if (out_last_hs) begin
        occ <= 1'b0;
      end
    end
  end

  generate
    for (genvar k = 0; k < FRAME_LEN; k++) begin : g_word
      assign words[k] = obuf[k*DOUT_W +: DOUT_W];
    end
  endgenerate

  // Output stream view of the buffer
  always_comb begin
    m_valid = occ;
    m_data  = occ ? words[rd_idx] : '0;
    m_last  = occ & (rd_idx == LAST_IDX);
    busy    = (in_st != FILL) | occ;
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_frame_sequencer
// Description : Directed self-checking bench for fir_frame_sequencer with a
//               behavioural FIR stub (B_k = 3 * sign-extended A_k, delayed
//               FIR_LAT clocks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_frame_sequencer;

  localparam int FRAME_LEN = 32;
  localparam int DIN_W     = 12;
  localparam int DOUT_W    = 29;
  localparam int FIR_LAT   = 2;
  localparam int CNT_W     = 16;

  logic                         clk     = 1'b0;
  logic                         reset   = 1'b1;
  logic                         s_valid = 1'b0;
  logic                         m_ready = 1'b0;
  logic [DIN_W-1:0]             s_data  = '0;
  logic                         s_ready, fir_load, m_valid, m_last, busy;
  logic [FRAME_LEN*DIN_W-1:0]   fir_din;
  logic [FRAME_LEN*DOUT_W-1:0]  fir_dout;
  logic [DOUT_W-1:0]            m_data;
  logic [CNT_W-1:0]             frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  fir_frame_sequencer #(
    .FRAME_LEN(FRAME_LEN), .DIN_W(DIN_W), .DOUT_W(DOUT_W),
    .FIR_LAT(FIR_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fir_load(fir_load), .fir_din(fir_din), .fir_dout(fir_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIR stub
  logic [FRAME_LEN*DOUT_W-1:0] stub_comb;
  logic [FRAME_LEN*DOUT_W-1:0] stub_pipe [FIR_LAT];
  always_comb begin
    stub_comb = '0;
    for (int k = 0; k < FRAME_LEN; k++)
      stub_comb[k*DOUT_W +: DOUT_W] = DOUT_W'($signed(fir_din[k*DIN_W +: DIN_W]) * 3);
  end
  always @(posedge clk) begin
    stub_pipe[0] <= stub_comb;
    for (int i = 1; i < FIR_LAT; i++) stub_pipe[i] <= stub_pipe[i-1];
  end
  assign fir_dout = stub_pipe[FIR_LAT-1];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Drives count samples base, base+step, ...; t_last = cycle of final handshake
  task automatic send_frame(input logic [DIN_W-1:0] base, input logic [DIN_W-1:0] step,
                            input int count, input bit gappy, output int t_last);
    logic [DIN_W-1:0] d;
    bit tog, done;
    int waitc;
    d = base; tog = 1'b0; t_last = -1;
    for (int i = 0; i < count; i++) begin
      done = 1'b0; waitc = 0;
      while (!done) begin
        @(negedge clk);
        if (gappy) tog = ~tog;
        s_valid = gappy ? tog : 1'b1;
        s_data  = d;
        if (s_valid && s_ready) begin done = 1'b1; t_last = cyc; end
        @(posedge clk);
        waitc++;
        if (!done && waitc > 200) begin
          n_cmp++; n_err++;
          $display("FAIL send_timeout: sample %0d s_ready=%b required 1", i, s_ready);
          #1 s_valid = 1'b0;
          return;
        end
      end
      d = d + step;
    end
    #1 s_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    n_cmp++; if ({s_ready, fir_load, m_valid, m_last, busy} !== 5'b10000) begin n_err++;
      $display("FAIL rst_flags: got %b required 10000", {s_ready, fir_load, m_valid, m_last, busy}); end
    n_cmp++; if (fir_din !== '0) begin n_err++; $display("FAIL rst_fir_din: got %h required 0", fir_din); end
    n_cmp++; if (m_data !== '0) begin n_err++; $display("FAIL rst_m_data: got %h required 0", m_data); end
    n_cmp++; if (frame_cnt !== '0) begin n_err++; $display("FAIL rst_frame_cnt: got %0d required 0", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    int t, loads, load_cyc, beats, first;
    do_reset();
    m_ready = 1'b1;
    send_frame(12'h001, 12'h001, 32, 1'b0, t);
    loads = 0; load_cyc = -1; beats = 0; first = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (fir_load) begin loads++; load_cyc = cyc; end
      if (m_valid) begin
        if (first < 0) begin
          first = cyc;
          n_cmp++; if (first != t + FIR_LAT + 2) begin n_err++;
            $display("FAIL b2b_first_beat: got cycle %0d required %0d", first, t + FIR_LAT + 2); end
        end
        n_cmp++; if (m_data !== DOUT_W'(3 * (beats + 1))) begin n_err++;
          $display("FAIL b2b_data beat %0d: got %0d required %0d", beats, m_data, 3 * (beats + 1)); end
        n_cmp++; if (m_last !== (beats == 31)) begin n_err++;
          $display("FAIL b2b_last beat %0d: got %b required %b", beats, m_last, beats == 31); end
        n_cmp++; if (cyc != first + beats) begin n_err++;
          $display("FAIL b2b_gap beat %0d: got cycle %0d required %0d", beats, cyc, first + beats); end
        beats++;
      end
    end
    n_cmp++; if (loads != 1) begin n_err++; $display("FAIL b2b_load_count: got %0d required 1", loads); end
    n_cmp++; if (load_cyc != t + 1) begin n_err++;
      $display("FAIL b2b_load_cycle: got %0d required %0d", load_cyc, t + 1); end
    n_cmp++; if (beats != 32) begin n_err++; $display("FAIL b2b_beats: got %0d required 32", beats); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL b2b_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_backpressure();
    int t, beats, p, c;
    bit stall_prev, prev_last;
    logic [DOUT_W-1:0] prev_data;
    do_reset();
    send_frame(12'h001, 12'h001, 32, 1'b0, t);
    beats = 0; p = 0; c = 0; stall_prev = 1'b0; prev_last = 1'b0; prev_data = '0;
    while (beats < 32 && c < 300) begin
      @(negedge clk);
      c++;
      if (m_valid) begin
        m_ready = (p % 3 == 0);
        p++;
        if (stall_prev) begin
          n_cmp++; if (m_data !== prev_data || m_last !== prev_last) begin n_err++;
            $display("FAIL bp_stall_hold: got %0d/%b required %0d/%b", m_data, m_last, prev_data, prev_last); end
        end
        n_cmp++; if (m_data !== DOUT_W'(3 * (beats + 1))) begin n_err++;
          $display("FAIL bp_data beat %0d: got %0d required %0d", beats, m_data, 3 * (beats + 1)); end
        n_cmp++; if (m_last !== (beats == 31)) begin n_err++;
          $display("FAIL bp_last beat %0d: got %b required %b", beats, m_last, beats == 31); end
        stall_prev = !m_ready; prev_data = m_data; prev_last = m_last;
        if (m_ready) beats++;
      end else begin
        m_ready = 1'b0;
        if (stall_prev) begin n_cmp++; n_err++;
          $display("FAIL bp_valid_drop: got m_valid=0 required 1"); end
        stall_prev = 1'b0;
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
    n_cmp++; if (beats != 32) begin n_err++; $display("FAIL bp_beats: got %0d required 32", beats); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle: got m_valid=%b required 0", m_valid); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL bp_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_overlap();
    int t1, t2;
    logic [DOUT_W-1:0] exp_d;
    do_reset();
    m_ready = 1'b0;
    send_frame(12'hFFF, 12'h000, 32, 1'b0, t1);
    send_frame(12'h7FF, 12'h000, 32, 1'b0, t2);
    repeat (5) @(negedge clk);
    n_cmp++; if ({s_ready, busy, m_valid, fir_load} !== 4'b0110) begin n_err++;
      $display("FAIL ov_hold_flags: got %b required 0110", {s_ready, busy, m_valid, fir_load}); end
    n_cmp++; if (m_data !== 29'h1FFFFFFD) begin n_err++;
      $display("FAIL ov_hold_data: got %h required 1FFFFFFD", m_data); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL ov_cnt1: got %0d required 1", frame_cnt); end
    for (int b = 0; b < 64; b++) begin
      if (b > 0) @(negedge clk);
      m_ready = 1'b1;
      exp_d = (b < 32) ? 29'h1FFFFFFD : 29'd6141;
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL ov_valid beat %0d: got 0 required 1", b); end
      n_cmp++; if (m_data !== exp_d) begin n_err++;
        $display("FAIL ov_data beat %0d: got %h required %h", b, m_data, exp_d); end
      n_cmp++; if (m_last !== (b == 31 || b == 63)) begin n_err++;
        $display("FAIL ov_last beat %0d: got %b required %b", b, m_last, (b == 31 || b == 63)); end
      if (b == 31) begin
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL ov_blocked: got s_ready=%b required 0", s_ready); end
      end
      if (b == 32) begin
        n_cmp++; if (frame_cnt !== 16'd2) begin n_err++; $display("FAIL ov_cnt2: got %0d required 2", frame_cnt); end
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
    n_cmp++; if ({m_valid, s_ready, busy} !== 3'b010) begin n_err++;
      $display("FAIL ov_end_flags: got %b required 010", {m_valid, s_ready, busy}); end
  endtask

  task automatic test_gappy();
    int t, beats;
    do_reset();
    m_ready = 1'b1;
    send_frame(12'h800, 12'h001, 32, 1'b1, t);
    beats = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (m_valid) begin
        n_cmp++; if (m_data !== DOUT_W'(3 * (beats - 2048))) begin n_err++;
          $display("FAIL gap_data word %0d: got %h required %h", beats, m_data, DOUT_W'(3 * (beats - 2048))); end
        n_cmp++; if (m_last !== (beats == 31)) begin n_err++;
          $display("FAIL gap_last word %0d: got %b required %b", beats, m_last, beats == 31); end
        beats++;
      end
    end
    n_cmp++; if (beats != 32) begin n_err++; $display("FAIL gap_beats: got %0d required 32", beats); end
  endtask

  task automatic test_reset_mid();
    int t, beats, stale;
    do_reset();
    m_ready = 1'b1;
    send_frame(12'h0A0, 12'h001, 17, 1'b0, t);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (fir_din !== '0) begin n_err++; $display("FAIL rmid_fir_din: got %h required 0", fir_din); end
    n_cmp++; if ({s_ready, fir_load, m_valid, m_last, busy} !== 5'b10000) begin n_err++;
      $display("FAIL rmid_flags: got %b required 10000", {s_ready, fir_load, m_valid, m_last, busy}); end
    @(negedge clk);
    reset = 1'b1;
    send_frame(12'h100, 12'h001, 32, 1'b0, t);
    beats = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (m_valid) begin
        n_cmp++; if (m_data !== DOUT_W'(3 * (256 + beats))) begin n_err++;
          $display("FAIL rmid_data word %0d: got %0d required %0d", beats, m_data, 3 * (256 + beats)); end
        beats++;
      end
    end
    n_cmp++; if (beats != 32) begin n_err++; $display("FAIL rmid_beats: got %0d required 32", beats); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL rmid_cnt: got %0d required 1", frame_cnt); end

    // second frame, reset while draining
    send_frame(12'h200, 12'h001, 32, 1'b0, t);
    beats = 0;
    for (int c = 0; c < 60 && beats < 10; c++) begin
      @(negedge clk);
      if (m_valid) beats++;
    end
    @(negedge clk);
    n_cmp++; if (m_valid !== 1'b1 || m_data !== DOUT_W'(3 * (512 + 10))) begin n_err++;
      $display("FAIL rdrain_pre: got %b/%0d required 1/%0d", m_valid, m_data, 3 * 522); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({m_valid, m_last, busy, s_ready} !== 4'b0001) begin n_err++;
      $display("FAIL rdrain_flags: got %b required 0001", {m_valid, m_last, busy, s_ready}); end
    n_cmp++; if (m_data !== '0) begin n_err++; $display("FAIL rdrain_data: got %h required 0", m_data); end
    n_cmp++; if (frame_cnt !== '0) begin n_err++; $display("FAIL rdrain_cnt: got %0d required 0", frame_cnt); end
    @(negedge clk);
    reset = 1'b1;
    stale = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_valid) stale++;
    end
    n_cmp++; if (stale != 0) begin n_err++; $display("FAIL rdrain_stale: got %0d beats required 0", stale); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_overlap();
    test_gappy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
